// File: rtl/vx_imadd_pipe.sv
// vx_imadd_pipe: lane-parallel integer multiply-add unit with an elastic pipeline.
// Each stage has its own valid bit. A stage loads whenever it or any stage
// below it is empty, or when the consumer is ready. Under backpressure this
// lets bubbles collapse, and a full pipe still sustains one result per cycle.
module vx_imadd_pipe #(
  parameter int LANES    = 4,
  parameter int DATAW    = 32,
  parameter int LATENCY  = 3,
  parameter int TAGW     = 8,
  parameter int SATURATE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic [2:0]             op,
  input  logic                   is_signed,
  input  logic [LANES-1:0]       lane_mask,
  input  logic [TAGW-1:0]        tag_in,
  input  logic [LANES*DATAW-1:0] dataa,
  input  logic [LANES*DATAW-1:0] datab,
  input  logic [LANES*DATAW-1:0] datac,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [LANES*DATAW-1:0] result,
  output logic [LANES-1:0]       ovf,
  output logic [TAGW-1:0]        tag_out,
  output logic                   busy
);

  // Intermediate precision holds a full signed/unsigned product plus one add.
  localparam int IW = 2*DATAW + 2;
  localparam int PW = LANES*DATAW + LANES + TAGW;

  localparam logic [2:0] OP_MADD  = 3'd0;
  localparam logic [2:0] OP_MSUB  = 3'd1;
  localparam logic [2:0] OP_NMADD = 3'd2;
  localparam logic [2:0] OP_NMSUB = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_ADD   = 3'd5;
  localparam logic [2:0] OP_SUB   = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam logic signed [IW-1:0] SMAX = (IW'(1) << (DATAW-1)) - IW'(1);
  localparam logic signed [IW-1:0] SMIN = -(IW'(1) << (DATAW-1));
  localparam logic signed [IW-1:0] UMAX = (IW'(1) << DATAW) - IW'(1);

  logic [LANES*DATAW-1:0] res_in;
  logic [LANES-1:0]       ovf_in;

  logic [LATENCY-1:0]     valid_q;
  logic [LATENCY-1:0]     valid_d;
  logic [LATENCY-1:0]     load;
  logic [LATENCY:0]       v_chain;
  logic [PW-1:0]          data_q  [LATENCY];
  logic [PW-1:0]          d_chain [LATENCY+1];
  logic [PW-1:0]          out_payload;

  // Per-lane arithmetic, evaluated on the request as presented at the input.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATAW-1:0]        a_l, b_l, c_l;
    logic signed [IW-1:0]    a_x, b_x, c_x, p_x, s_x;
    logic                    out_of_range;
    logic                    lane_en;
    logic [DATAW-1:0]        lane_res;
    logic                    lane_ovf;

    assign a_l = dataa[gi*DATAW +: DATAW];
    assign b_l = datab[gi*DATAW +: DATAW];
    assign c_l = datac[gi*DATAW +: DATAW];

    // Extend operands, form the op result, then range-check and clamp or wrap it.
    always_comb begin
      a_x = {{(IW-DATAW){is_signed & a_l[DATAW-1]}}, a_l};
      b_x = {{(IW-DATAW){is_signed & b_l[DATAW-1]}}, b_l};
      c_x = {{(IW-DATAW){is_signed & c_l[DATAW-1]}}, c_l};
      p_x = a_x * b_x;
      case (op)
        OP_MADD:  s_x = p_x + c_x;
        OP_MSUB:  s_x = p_x - c_x;
        OP_NMADD: s_x = -p_x - c_x;
        OP_NMSUB: s_x = c_x - p_x;
        OP_MUL:   s_x = p_x;
        OP_ADD:   s_x = a_x + b_x;
        OP_SUB:   s_x = a_x - b_x;
        default:  s_x = '0;
      endcase
      if (is_signed) begin
        out_of_range = (s_x < SMIN) || (s_x > SMAX);
      end else begin
        out_of_range = s_x[IW-1] || (s_x > UMAX);
      end
      lane_en = lane_mask[gi] && (op != OP_RSVD);
      lane_res = '0;
      lane_ovf = 1'b0;
      if (lane_en) begin
        lane_ovf = out_of_range;
        if ((SATURATE != 0) && out_of_range) begin
          if (is_signed) begin
            lane_res = s_x[IW-1] ? SMIN[DATAW-1:0] : SMAX[DATAW-1:0];
          end else begin
            lane_res = s_x[IW-1] ? '0 : '1;
          end
        end else begin
          lane_res = s_x[DATAW-1:0];
        end
      end
    end

    assign res_in[gi*DATAW +: DATAW] = lane_res;
    assign ovf_in[gi]                = lane_ovf;
  end

  // Stage i loads when any stage from i to the end is empty, or the consumer
  // takes the last entry; this is the recursive advance rule unrolled.
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_load
    assign load[gi] = ready_out | ~(&valid_q[LATENCY-1:gi]);
  end

  assign v_chain = {valid_q, valid_in};

  // Upstream payload for each stage: the fresh computation for stage 0,
  // the previous stage's register for the rest.
  always_comb begin
    d_chain[0] = {tag_in, ovf_in, res_in};
    for (int i = 0; i < LATENCY; i++) begin
      d_chain[i+1] = data_q[i];
    end
  end

  // Next valid bits: a loading stage takes its upstream valid, otherwise it holds.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < LATENCY; i++) begin
      if (load[i]) valid_d[i] = v_chain[i];
    end
  end

  // Valid bits; a reset drops every in-flight entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload registers move together with their valid bits; no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++) begin
      if (load[i]) data_q[i] <= d_chain[i];
    end
  end

  assign out_payload = data_q[LATENCY-1];
  assign ready_in    = load[0];
  assign valid_out   = valid_q[LATENCY-1];
  assign busy        = |valid_q;
  assign result      = valid_out ? out_payload[LANES*DATAW-1:0] : '0;
  assign ovf         = valid_out ? out_payload[LANES*DATAW +: LANES] : '0;
  assign tag_out     = valid_out ? out_payload[PW-1 -: TAGW] : '0;

endmodule

// File: tb/tb_vx_imadd_pipe.sv
// Bench for vx_imadd_pipe. Two instances, one wrapping and one saturating,
// receive the same stimulus. A scoreboard queue holds the expected result for
// each accepted request, and a monitor pops and compares on every output transfer.
module tb_vx_imadd_pipe;
  localparam int LANES = 4, DATAW = 32, LATENCY = 3, TAGW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, valid_in, ready_out, is_signed;
  logic [2:0] op;
  logic [3:0] lane_mask;
  logic [7:0] tag_in;
  logic [127:0] dataa, datab, datac;

  logic w_ready_in, w_valid_out, w_busy, s_ready_in, s_valid_out, s_busy;
  logic [127:0] w_result, s_result;
  logic [3:0] w_ovf, s_ovf;
  logic [7:0] w_tag, s_tag;

  vx_imadd_pipe #(.LANES(LANES), .DATAW(DATAW), .LATENCY(LATENCY), .TAGW(TAGW), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(w_ready_in), .op(op),
    .is_signed(is_signed), .lane_mask(lane_mask), .tag_in(tag_in), .dataa(dataa),
    .datab(datab), .datac(datac), .valid_out(w_valid_out), .ready_out(ready_out),
    .result(w_result), .ovf(w_ovf), .tag_out(w_tag), .busy(w_busy));

  vx_imadd_pipe #(.LANES(LANES), .DATAW(DATAW), .LATENCY(LATENCY), .TAGW(TAGW), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(s_ready_in), .op(op),
    .is_signed(is_signed), .lane_mask(lane_mask), .tag_in(tag_in), .dataa(dataa),
    .datab(datab), .datac(datac), .valid_out(s_valid_out), .ready_out(ready_out),
    .result(s_result), .ovf(s_ovf), .tag_out(s_tag), .busy(s_busy));

  typedef struct {
    logic [127:0] rw;
    logic [127:0] rs;
    logic [3:0]   ov;
    logic [7:0]   tag;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   out_cyc[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every output transfer pops one expected entry.
  always @(negedge clk) begin
    if (reset && w_valid_out && ready_out) begin
      if (sb.size() == 0) begin
        chk("spurious_valid_out", 128'(w_valid_out), 128'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("wrap_result", w_result, mon_e.rw);
        chk("wrap_ovf", 128'(w_ovf), 128'(mon_e.ov));
        chk("wrap_tag", 128'(w_tag), 128'(mon_e.tag));
        chk("sat_valid", 128'(s_valid_out), 128'(1));
        chk("sat_result", s_result, mon_e.rs);
        chk("sat_ovf", 128'(s_ovf), 128'(mon_e.ov));
        chk("sat_tag", 128'(s_tag), 128'(mon_e.tag));
        if (mon_e.lat >= 0) chk("latency", 128'(cyc - mon_e.acc), 128'(mon_e.lat));
        out_cyc.push_back(cyc);
        $display("out tag=%h wrap=%h sat=%h ovf=%b cyc=%0d", w_tag, w_result, s_result, w_ovf, cyc);
      end
    end
  end

  // Present one request (operands broadcast to all lanes) and wait until accepted.
  task automatic issue(input logic [2:0] o, input logic sg, input logic [3:0] m, input logic [7:0] t,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] ew, input logic [31:0] es, input logic eo,
                       input int lat, output int waits);
    exp_t e;
    op = o; is_signed = sg; lane_mask = m; tag_in = t;
    dataa = {4{a}}; datab = {4{b}}; datac = {4{c}};
    valid_in = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      e.rw[i*32 +: 32] = m[i] ? ew : 32'h0;
      e.rs[i*32 +: 32] = m[i] ? es : 32'h0;
    end
    e.ov = m & {4{eo}};
    e.tag = t;
    e.lat = lat;
    waits = 0;
    @(negedge clk);
    while (!w_ready_in && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!w_ready_in) begin
      chk("accept_timeout", 128'(w_ready_in), 128'(1));
      valid_in = 1'b0;
      return;
    end
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 128'(sb.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_consecutive(input string name, input int n);
    for (int i = 1; i < n; i++) begin
      if (i < out_cyc.size()) chk(name, 128'(out_cyc[i] - out_cyc[i-1]), 128'(1));
      else chk(name, 128'(out_cyc.size()), 128'(n));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, sb=%0d", sb.size());
    $fatal(1);
  end

  initial begin
    reset = 1'b0; valid_in = 1'b0; ready_out = 1'b1; is_signed = 1'b0;
    op = 3'd0; lane_mask = 4'hF; tag_in = 8'h0; dataa = '0; datab = '0; datac = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_out", 128'(w_valid_out), 128'(0));
    chk("rst_busy", 128'(w_busy), 128'(0));
    chk("rst_result", w_result, 128'(0));
    chk("rst_ovf_tag", 128'({w_ovf, w_tag}), 128'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready_in", 128'(w_ready_in), 128'(1));
    @(posedge clk);
    #1;

    // Signed MADD 3*-4+5 = -7, latency 3.
    issue(3'd0, 1'b1, 4'hF, 8'h11, 32'd3, 32'hFFFFFFFC, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFF9, 1'b0, 3, w);
    drain();

    // Back-to-back stream of ADDs, a=i, b=100.
    out_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      issue(3'd5, 1'b0, 4'hF, 8'(8'h20 + i), 32'(i), 32'd100, 32'd0, 32'(100 + i), 32'(100 + i), 1'b0, 3, w);
      chk("stream_ready_in", 128'(w), 128'(0));
    end
    drain();
    chk_consecutive("stream_consecutive", 10);

    // Backpressure: three absorbed, further requests stall until release.
    ready_out = 1'b0;
    out_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      issue(3'd5, 1'b0, 4'hF, 8'(8'h40 + i), 32'(i), 32'd1000, 32'd0, 32'(1000 + i), 32'(1000 + i), 1'b0, -1, w);
      chk("bp_accept", 128'(w), 128'(0));
    end
    fork
      begin
        int w2;
        issue(3'd5, 1'b0, 4'hF, 8'h43, 32'd3, 32'd1000, 32'd0, 32'd1003, 32'd1003, 1'b0, -1, w2);
        issue(3'd5, 1'b0, 4'hF, 8'h44, 32'd4, 32'd1000, 32'd0, 32'd1004, 32'd1004, 1'b0, -1, w2);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_ready_in_low", 128'(w_ready_in), 128'(0));
        chk("bp_busy", 128'(w_busy), 128'(1));
        chk("bp_sb_depth", 128'(sb.size()), 128'(3));
        @(posedge clk);
        #1 ready_out = 1'b1;
      end
    join
    drain();
    chk_consecutive("bp_consecutive", 5);

    // Bubble squeeze: idle cycle between requests while output is stalled.
    ready_out = 1'b0;
    out_cyc.delete();
    issue(3'd4, 1'b0, 4'hF, 8'h50, 32'd1, 32'd7, 32'd0, 32'd7, 32'd7, 1'b0, -1, w);
    @(posedge clk);
    #1;
    issue(3'd4, 1'b0, 4'hF, 8'h51, 32'd2, 32'd7, 32'd0, 32'd14, 32'd14, 1'b0, -1, w);
    issue(3'd4, 1'b0, 4'hF, 8'h52, 32'd3, 32'd7, 32'd0, 32'd21, 32'd21, 1'b0, -1, w);
    chk("bubble_no_wait", 128'(w), 128'(0));
    @(negedge clk);
    chk("bubble_full_ready_in", 128'(w_ready_in), 128'(0));
    chk("bubble_valid_out", 128'(w_valid_out), 128'(1));
    @(posedge clk);
    #1 ready_out = 1'b1;
    drain();
    chk_consecutive("bubble_consecutive", 3);

    // Arithmetic corner vectors: {wrap, sat, ovf}.
    issue(3'd4, 1'b1, 4'hF, 8'h60, 32'h40000000, 32'd4, 32'd0, 32'h00000000, 32'h7FFFFFFF, 1'b1, 3, w);
    issue(3'd6, 1'b0, 4'hF, 8'h61, 32'd1, 32'd2, 32'd0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 3, w);
    issue(3'd1, 1'b1, 4'b0101, 8'h62, 32'd2, 32'd3, 32'd1, 32'd5, 32'd5, 1'b0, 3, w);
    issue(3'd2, 1'b1, 4'hF, 8'h63, 32'd2, 32'd3, 32'd4, 32'hFFFFFFF6, 32'hFFFFFFF6, 1'b0, 3, w);
    issue(3'd3, 1'b1, 4'hF, 8'h64, 32'd2, 32'd3, 32'd10, 32'd4, 32'd4, 1'b0, 3, w);
    issue(3'd7, 1'b1, 4'hF, 8'h65, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 3, w);
    issue(3'd0, 1'b0, 4'hF, 8'h66, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 3, w);
    issue(3'd6, 1'b1, 4'hF, 8'h67, 32'h80000000, 32'd1, 32'd0, 32'h7FFFFFFF, 32'h80000000, 1'b1, 3, w);
    issue(3'd5, 1'b0, 4'hF, 8'h68, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h00000000, 32'hFFFFFFFF, 1'b1, 3, w);
    issue(3'd4, 1'b1, 4'hF, 8'h69, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd1, 1'b0, 3, w);
    drain();

    // Reset with two entries in flight: both dropped.
    issue(3'd5, 1'b0, 4'hF, 8'h70, 32'd1, 32'd1, 32'd0, 32'd2, 32'd2, 1'b0, 3, w);
    issue(3'd5, 1'b0, 4'hF, 8'h71, 32'd2, 32'd2, 32'd0, 32'd4, 32'd4, 1'b0, 3, w);
    reset = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_in", 128'(w_ready_in), 128'(1));
    chk("mid_rst_busy", 128'(w_busy), 128'(0));
    for (int i = 0; i < 5; i++) begin
      chk("mid_rst_no_valid_out", 128'(w_valid_out | s_valid_out), 128'(0));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
